duck_controller: RTL

Per-duck motion and hit-state engine that sits directly upstream of `color_mapper`. It owns the duck's position and life cycle: spawn, fly with edge bounce, shot hit, hit pause, fall, and optional escape. Each pixel it compares the VGA scan coordinates (`DrawX`/`DrawY`) against the duck bounding box and drives the `is_duck` / `is_dead` flags consumed by `color_mapper`. Motion advances once per video frame; shots are evaluated on any clock.

---
 rtl/duck_controller_if.sv | 27 ++
 rtl/duck_controller.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/duck_controller_if.sv
// duck_controller_if: pixel/control bundle between the game logic and one duck.
//   master: game logic / video side (drives scan coords, spawn and shot requests)
//   slave : duck_controller (returns pixel flags, state and event pulses)
//   DrawX/DrawY    scan coordinates
//   spawn*         launch request with column and direction
//   shot_*         trigger pulse with crosshair coordinates
//   is_duck/is_dead pixel flags, state, hit/escaped pulses, busy
interface duck_controller_if;
  logic [9:0] DrawX, DrawY;
  logic       spawn;
  logic [9:0] spawn_x;
  logic       spawn_dir;
  logic       shot_valid;
  logic [9:0] shot_x, shot_y;
  logic       is_duck, is_dead;
  logic [2:0] state;
  logic       hit, escaped, busy;

  modport master (
    output DrawX, DrawY, spawn, spawn_x, spawn_dir, shot_valid, shot_x, shot_y,
    input  is_duck, is_dead, state, hit, escaped, busy
  );
  modport slave (
    input  DrawX, DrawY, spawn, spawn_x, spawn_dir, shot_valid, shot_x, shot_y,
    output is_duck, is_dead, state, hit, escaped, busy
  );
endinterface

// File: rtl/duck_controller.sv
// duck_controller: per-duck motion and hit-state engine feeding color_mapper.
// Spawn, fly with edge bounce, shot hit, hit pause, fall, optional escape.
// Ports:
//   Clk, Reset_n (async active-low), frame_clk (vsync, rising edge = new frame)
//   bus (duck_controller_if.slave): DrawX/DrawY, spawn/spawn_x/spawn_dir,
//     shot_valid/shot_x/shot_y in; is_duck, is_dead, state, hit, escaped, busy out
// Optional feature: define DUCK_ESCAPE_EN to let an unshot duck leave the top
// edge after ESCAPE_FRAMES flying frames; otherwise it flies until shot.
module duck_controller #(
  parameter int DUCK_W        = 32,
  parameter int DUCK_H        = 32,
  parameter int X_STEP        = 2,
  parameter int Y_STEP        = 1,
  parameter int FALL_STEP     = 3,
  parameter int GROUND_Y      = 360,
  parameter int HIT_FRAMES    = 30,
  parameter int ESCAPE_FRAMES = 600
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic frame_clk,
  duck_controller_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_FLY = 3'd1, S_HIT = 3'd2, S_FALL = 3'd3, S_ESCAPE = 3'd4
  } state_e;

  localparam logic [10:0] X_LIM   = 11'(640 - DUCK_W - X_STEP);
  localparam logic [10:0] Y_FLOOR = 11'(GROUND_Y - DUCK_H);
  localparam logic [10:0] Y_LIM   = 11'(GROUND_Y - DUCK_H - Y_STEP);
  localparam logic [10:0] W_M1    = 11'(DUCK_W - 1);
  localparam logic [10:0] H_M1    = 11'(DUCK_H - 1);
  localparam logic [10:0] FS      = 11'(FALL_STEP);
  localparam logic [9:0]  XS      = 10'(X_STEP);
  localparam logic [9:0]  YS      = 10'(Y_STEP);
  localparam logic [9:0]  HIT_LAST = 10'(HIT_FRAMES - 1);
`ifdef DUCK_ESCAPE_EN
  localparam logic [9:0]  ESC_LAST = 10'(ESCAPE_FRAMES - 1);
  logic esc_q, esc_d;
`endif

  state_e     state_q, state_d;
  logic [9:0] x_q, x_d, y_q, y_d, cnt_q, cnt_d;
  logic       xdir_q, xdir_d, yup_q, yup_d;   // xdir 1 = right, yup 1 = moving up
  logic       hit_q, hit_d;
  logic [2:0] fs_q, fs_d;                     // [1:0] synchronizer, [2] edge history
  logic       tick_q, tick_d;

  logic [10:0] x_e, y_e, y_fall;
  logic [9:0]  cnt_inc;
  logic        shot_in, inbox;

  always_comb begin
    x_e     = {1'b0, x_q};
    y_e     = {1'b0, y_q};
    y_fall  = y_e + FS;
    cnt_inc = (cnt_q == 10'h3FF) ? cnt_q : cnt_q + 10'd1;
    shot_in = ({1'b0, bus.shot_x} >= x_e) && ({1'b0, bus.shot_x} <= x_e + W_M1) &&
              ({1'b0, bus.shot_y} >= y_e) && ({1'b0, bus.shot_y} <= y_e + H_M1);
    inbox   = ({1'b0, bus.DrawX} >= x_e) && ({1'b0, bus.DrawX} <= x_e + W_M1) &&
              ({1'b0, bus.DrawY} >= y_e) && ({1'b0, bus.DrawY} <= y_e + H_M1);
  end

  always_comb begin
    fs_d    = {fs_q[1:0], frame_clk};
    tick_d  = fs_q[1] & ~fs_q[2];
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    xdir_d  = xdir_q;
    yup_d   = yup_q;
    cnt_d   = cnt_q;
    hit_d   = 1'b0;
`ifdef DUCK_ESCAPE_EN
    esc_d   = 1'b0;
`endif
    case (state_q)
      S_IDLE: if (bus.spawn) begin
        state_d = S_FLY;
        x_d     = bus.spawn_x;
        y_d     = Y_FLOOR[9:0];
        xdir_d  = bus.spawn_dir;
        yup_d   = 1'b1;
        cnt_d   = '0;
      end
      S_FLY: begin
        // a hit takes priority over a same-cycle frame tick
        if (bus.shot_valid && shot_in) begin
          hit_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_HIT;
        end else if (tick_q) begin
`ifdef DUCK_ESCAPE_EN
          if (cnt_q == ESC_LAST) state_d = S_ESCAPE;
          else
`endif
          begin
            cnt_d = cnt_inc;
            if (xdir_q) begin
              if (x_e >= X_LIM) begin xdir_d = 1'b0; x_d = x_q - XS; end
              else x_d = x_q + XS;
            end else begin
              if (x_q < XS) begin xdir_d = 1'b1; x_d = x_q + XS; end
              else x_d = x_q - XS;
            end
            if (yup_q) begin
              if (y_q < YS) begin yup_d = 1'b0; y_d = y_q + YS; end
              else y_d = y_q - YS;
            end else begin
              if (y_e >= Y_LIM) begin yup_d = 1'b1; y_d = y_q - YS; end
              else y_d = y_q + YS;
            end
          end
        end
      end
      S_HIT: if (tick_q) begin
        cnt_d = cnt_inc;
        if (cnt_q == HIT_LAST) state_d = S_FALL;
      end
      S_FALL: if (tick_q) begin
        if (y_fall >= Y_FLOOR) begin
          y_d     = Y_FLOOR[9:0];
          state_d = S_IDLE;
        end else begin
          y_d = y_fall[9:0];
        end
      end
`ifdef DUCK_ESCAPE_EN
      S_ESCAPE: if (tick_q) begin
        if (y_q < YS) begin
          esc_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          y_d = y_q - YS;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      xdir_q  <= 1'b1;
      yup_q   <= 1'b1;
      cnt_q   <= '0;
      hit_q   <= 1'b0;
      fs_q    <= '0;
      tick_q  <= 1'b0;
`ifdef DUCK_ESCAPE_EN
      esc_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      xdir_q  <= xdir_d;
      yup_q   <= yup_d;
      cnt_q   <= cnt_d;
      hit_q   <= hit_d;
      fs_q    <= fs_d;
      tick_q  <= tick_d;
`ifdef DUCK_ESCAPE_EN
      esc_q   <= esc_d;
`endif
    end
  end

  assign bus.state   = state_q;
  assign bus.busy    = (state_q != S_IDLE);
  assign bus.hit     = hit_q;
  assign bus.is_duck = inbox && (state_q == S_FLY || state_q == S_ESCAPE);
  assign bus.is_dead = inbox && (state_q == S_HIT || state_q == S_FALL);
`ifdef DUCK_ESCAPE_EN
  assign bus.escaped = esc_q;
`else
  assign bus.escaped = 1'b0;
`endif
endmodule
